// File: rtl/writeback_receive_wb.sv
// writeback_receive_wb
// Receiving end of the EX->WB interface. Holds one instruction in the
// EX->WB latch and commits it exactly once: register-file writes (GPR1,
// GPR2, MM), flags load, and an optional data-cache store through a
// req/ack handshake. While a store is outstanding WB_stall holds execute.
// A sticky dcache_err flags a store that waited ACK_TIMEOUT cycles in WAIT.
// REPNE support: saved_count captures the decremented count on commit and
// wb_repne_terminate_all pulses when the loop must end.
//
// Ports:
//   CLK, CLR                      clock, synchronous active-high reset
//   WB_ld_latches                 load enable for the EX->WB latch
//   WB_*_next                     incoming instruction bundle from execute
//   dcache_ack                    store accepted by the data cache
//   gpr1_*/gpr2_*/mm_*/flags_*    register-file and flags write ports
//   dcache_req/addr/wdata/size    store request to the data cache
//   WB_stall                      back-pressure to execute
//   wb_repne_terminate_all        single-cycle REPNE termination pulse
//   saved_count                   last committed REPNE count
//   dcache_err                    sticky store-ack timeout flag
module writeback_receive_wb #(
  parameter int ACK_TIMEOUT = 255,
  parameter int ZF_BIT      = 6
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        WB_ld_latches,
  input  logic        WB_V_next,
  input  logic [1:0]  WB_d2_datasize_all_next,
  input  logic        WB_ex_ld_gpr1_wb_next,
  input  logic        WB_ex_ld_gpr2_wb_next,
  input  logic        WB_ex_ld_mm_wb_next,
  input  logic        WB_ex_dcache_write_wb_next,
  input  logic        WB_d2_repne_wb_next,
  input  logic        WB_ld_flags_next,
  input  logic [31:0] WB_RESULT_A_next,
  input  logic [31:0] WB_RESULT_B_next,
  input  logic [31:0] WB_RESULT_C_next,
  input  logic [31:0] WB_FLAGS_next,
  input  logic [63:0] WB_RESULT_MM_next,
  input  logic [2:0]  WB_DR1_next,
  input  logic [2:0]  WB_DR2_next,
  input  logic [31:0] WB_ADDRESS_next,
  input  logic        dcache_ack,
  output logic        gpr1_we,
  output logic [2:0]  gpr1_dr,
  output logic [31:0] gpr1_data,
  output logic        gpr2_we,
  output logic [2:0]  gpr2_dr,
  output logic [31:0] gpr2_data,
  output logic        mm_we,
  output logic [2:0]  mm_dr,
  output logic [63:0] mm_data,
  output logic        flags_we,
  output logic [31:0] flags_data,
  output logic        dcache_req,
  output logic [31:0] dcache_addr,
  output logic [63:0] dcache_wdata,
  output logic [1:0]  dcache_size,
  output logic        WB_stall,
  output logic        wb_repne_terminate_all,
  output logic [31:0] saved_count,
  output logic        dcache_err
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Latch: valid bit (reset) and data fields (no reset, don't-care after CLR)
  logic        v_q, v_d;
  logic [1:0]  size_q, size_d;
  logic        ld_gpr1_q, ld_gpr1_d;
  logic        ld_gpr2_q, ld_gpr2_d;
  logic        ld_mm_q, ld_mm_d;
  logic        dwrite_q, dwrite_d;
  logic        repne_q, repne_d;
  logic        ld_flags_q, ld_flags_d;
  logic [31:0] res_a_q, res_a_d;
  logic [31:0] res_b_q, res_b_d;
  logic [31:0] res_c_q, res_c_d;
  logic [31:0] flags_q, flags_d;
  logic [63:0] res_mm_q, res_mm_d;
  logic [2:0]  dr1_q, dr1_d;
  logic [2:0]  dr2_q, dr2_d;
  logic [31:0] addr_q, addr_d;

  // Control state
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [31:0]     saved_count_q, saved_count_d;

  logic req_s;
  logic stall_s;
  logic commit_s;

  // Handshake and commit qualification
  always_comb begin
    req_s    = v_q & dwrite_q;
    stall_s  = req_s & ~dcache_ack;
    // A store commits only in the cycle its ack is seen, so its register
    // writes land together with the ack.
    commit_s = v_q & (~dwrite_q | dcache_ack);
  end

  // Output decode from the latched instruction
  always_comb begin
    gpr1_we      = commit_s & ld_gpr1_q;
    gpr1_dr      = dr1_q;
    gpr1_data    = res_a_q;
    // Same-DR GPR1/GPR2 writes are both driven; the register file gives GPR2 priority.
    gpr2_we      = commit_s & ld_gpr2_q;
    gpr2_dr      = dr2_q;
    gpr2_data    = res_b_q;
    mm_we        = commit_s & ld_mm_q;
    mm_dr        = dr1_q;
    mm_data      = res_mm_q;
    flags_we     = commit_s & ld_flags_q;
    flags_data   = flags_q;
    dcache_req   = req_s;
    dcache_addr  = addr_q;
    dcache_size  = size_q;
    if (size_q == 2'd3) begin
      dcache_wdata = res_mm_q;
    end else begin
      dcache_wdata = {32'd0, res_a_q};
    end
    WB_stall     = stall_s;
    wb_repne_terminate_all = commit_s & repne_q &
                             ((res_c_q == 32'd0) | flags_q[ZF_BIT]);
    saved_count  = saved_count_q;
    dcache_err   = err_q;
  end

  // Latch next-state: load, bubble when not stalled, hold while stalled
  always_comb begin
    v_d        = v_q;
    size_d     = size_q;
    ld_gpr1_d  = ld_gpr1_q;
    ld_gpr2_d  = ld_gpr2_q;
    ld_mm_d    = ld_mm_q;
    dwrite_d   = dwrite_q;
    repne_d    = repne_q;
    ld_flags_d = ld_flags_q;
    res_a_d    = res_a_q;
    res_b_d    = res_b_q;
    res_c_d    = res_c_q;
    flags_d    = flags_q;
    res_mm_d   = res_mm_q;
    dr1_d      = dr1_q;
    dr2_d      = dr2_q;
    addr_d     = addr_q;
    if (WB_ld_latches) begin
      v_d        = WB_V_next;
      size_d     = WB_d2_datasize_all_next;
      ld_gpr1_d  = WB_ex_ld_gpr1_wb_next;
      ld_gpr2_d  = WB_ex_ld_gpr2_wb_next;
      ld_mm_d    = WB_ex_ld_mm_wb_next;
      dwrite_d   = WB_ex_dcache_write_wb_next;
      repne_d    = WB_d2_repne_wb_next;
      ld_flags_d = WB_ld_flags_next;
      res_a_d    = WB_RESULT_A_next;
      res_b_d    = WB_RESULT_B_next;
      res_c_d    = WB_RESULT_C_next;
      flags_d    = WB_FLAGS_next;
      res_mm_d   = WB_RESULT_MM_next;
      dr1_d      = WB_DR1_next;
      dr2_d      = WB_DR2_next;
      addr_d     = WB_ADDRESS_next;
    end else if (!stall_s) begin
      // Bubble after use guarantees one commit per loaded instruction.
      v_d = 1'b0;
    end else begin
      v_d = v_q;
    end
  end

  // Store-wait FSM, timeout counter, sticky error and REPNE count
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    saved_count_d = saved_count_q;
    case (state_q)
      ST_IDLE: begin
        if (stall_s) begin
          state_d = ST_WAIT;
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (dcache_ack) begin
          state_d = ST_IDLE;
        end else begin
          // Counter saturates at ACK_TIMEOUT; the request is never aborted.
          if (cnt_q != CW'(ACK_TIMEOUT)) begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          end else begin
            cnt_d = cnt_q;
          end
          if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (commit_s && repne_q) begin
      saved_count_d = res_c_q;
    end else begin
      saved_count_d = saved_count_q;
    end
  end

  // Control registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (CLR) begin
      v_q           <= 1'b0;
      state_q       <= ST_IDLE;
      cnt_q         <= {CW{1'b0}};
      err_q         <= 1'b0;
      saved_count_q <= 32'd0;
    end else begin
      v_q           <= v_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      err_q         <= err_d;
      saved_count_q <= saved_count_d;
    end
  end

  // Latch data fields; meaningless while v_q is low, so no reset
  always_ff @(posedge CLK) begin
    size_q     <= size_d;
    ld_gpr1_q  <= ld_gpr1_d;
    ld_gpr2_q  <= ld_gpr2_d;
    ld_mm_q    <= ld_mm_d;
    dwrite_q   <= dwrite_d;
    repne_q    <= repne_d;
    ld_flags_q <= ld_flags_d;
    res_a_q    <= res_a_d;
    res_b_q    <= res_b_d;
    res_c_q    <= res_c_d;
    flags_q    <= flags_d;
    res_mm_q   <= res_mm_d;
    dr1_q      <= dr1_d;
    dr2_q      <= dr2_d;
    addr_q     <= addr_d;
  end

endmodule

// File: tb/tb_writeback_receive_wb.sv
// Testbench for writeback_receive_wb: directed scenarios followed by random
// traffic, all checked every cycle against a transaction-level model that
// tracks the currently held instruction, how long its store has been
// waiting for an ack, the sticky error and the saved REPNE count.
module tb_writeback_receive_wb;

  localparam int TO = 4;
  localparam int ZF = 6;

  typedef struct packed {
    logic        v;
    logic [1:0]  size;
    logic        g1;
    logic        g2;
    logic        mm;
    logic        st;
    logic        rep;
    logic        lf;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] f;
    logic [63:0] m;
    logic [2:0]  d1;
    logic [2:0]  d2;
    logic [31:0] addr;
  } instr_t;

  logic        CLK;
  logic        CLR;
  logic        WB_ld_latches;
  logic        WB_V_next;
  logic [1:0]  WB_d2_datasize_all_next;
  logic        WB_ex_ld_gpr1_wb_next;
  logic        WB_ex_ld_gpr2_wb_next;
  logic        WB_ex_ld_mm_wb_next;
  logic        WB_ex_dcache_write_wb_next;
  logic        WB_d2_repne_wb_next;
  logic        WB_ld_flags_next;
  logic [31:0] WB_RESULT_A_next;
  logic [31:0] WB_RESULT_B_next;
  logic [31:0] WB_RESULT_C_next;
  logic [31:0] WB_FLAGS_next;
  logic [63:0] WB_RESULT_MM_next;
  logic [2:0]  WB_DR1_next;
  logic [2:0]  WB_DR2_next;
  logic [31:0] WB_ADDRESS_next;
  logic        dcache_ack;
  logic        gpr1_we;
  logic [2:0]  gpr1_dr;
  logic [31:0] gpr1_data;
  logic        gpr2_we;
  logic [2:0]  gpr2_dr;
  logic [31:0] gpr2_data;
  logic        mm_we;
  logic [2:0]  mm_dr;
  logic [63:0] mm_data;
  logic        flags_we;
  logic [31:0] flags_data;
  logic        dcache_req;
  logic [31:0] dcache_addr;
  logic [63:0] dcache_wdata;
  logic [1:0]  dcache_size;
  logic        WB_stall;
  logic        wb_repne_terminate_all;
  logic [31:0] saved_count;
  logic        dcache_err;

  writeback_receive_wb #(.ACK_TIMEOUT(TO), .ZF_BIT(ZF)) u_dut (
    .CLK(CLK), .CLR(CLR), .WB_ld_latches(WB_ld_latches), .WB_V_next(WB_V_next),
    .WB_d2_datasize_all_next(WB_d2_datasize_all_next),
    .WB_ex_ld_gpr1_wb_next(WB_ex_ld_gpr1_wb_next),
    .WB_ex_ld_gpr2_wb_next(WB_ex_ld_gpr2_wb_next),
    .WB_ex_ld_mm_wb_next(WB_ex_ld_mm_wb_next),
    .WB_ex_dcache_write_wb_next(WB_ex_dcache_write_wb_next),
    .WB_d2_repne_wb_next(WB_d2_repne_wb_next), .WB_ld_flags_next(WB_ld_flags_next),
    .WB_RESULT_A_next(WB_RESULT_A_next), .WB_RESULT_B_next(WB_RESULT_B_next),
    .WB_RESULT_C_next(WB_RESULT_C_next), .WB_FLAGS_next(WB_FLAGS_next),
    .WB_RESULT_MM_next(WB_RESULT_MM_next), .WB_DR1_next(WB_DR1_next),
    .WB_DR2_next(WB_DR2_next), .WB_ADDRESS_next(WB_ADDRESS_next),
    .dcache_ack(dcache_ack),
    .gpr1_we(gpr1_we), .gpr1_dr(gpr1_dr), .gpr1_data(gpr1_data),
    .gpr2_we(gpr2_we), .gpr2_dr(gpr2_dr), .gpr2_data(gpr2_data),
    .mm_we(mm_we), .mm_dr(mm_dr), .mm_data(mm_data),
    .flags_we(flags_we), .flags_data(flags_data),
    .dcache_req(dcache_req), .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata),
    .dcache_size(dcache_size), .WB_stall(WB_stall),
    .wb_repne_terminate_all(wb_repne_terminate_all),
    .saved_count(saved_count), .dcache_err(dcache_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic        m_v      = 1'b0;
  instr_t      m_i      = '0;
  logic        m_err    = 1'b0;
  logic [31:0] m_saved  = 32'd0;
  int          m_waited = 0;
  logic        chk_en   = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic exp_stall(input logic ack);
    return m_v & m_i.st & ~ack;
  endfunction

  // One clock cycle: drive, check on the falling edge, advance the model on the rising edge.
  task automatic apply(input logic clr, input logic ld, input instr_t ins, input logic ack);
    logic e_req, e_stall, e_commit, e_term;
    logic [63:0] e_wdata;
    CLR = clr;
    WB_ld_latches = ld;
    WB_V_next = ins.v;
    WB_d2_datasize_all_next = ins.size;
    WB_ex_ld_gpr1_wb_next = ins.g1;
    WB_ex_ld_gpr2_wb_next = ins.g2;
    WB_ex_ld_mm_wb_next = ins.mm;
    WB_ex_dcache_write_wb_next = ins.st;
    WB_d2_repne_wb_next = ins.rep;
    WB_ld_flags_next = ins.lf;
    WB_RESULT_A_next = ins.a;
    WB_RESULT_B_next = ins.b;
    WB_RESULT_C_next = ins.c;
    WB_FLAGS_next = ins.f;
    WB_RESULT_MM_next = ins.m;
    WB_DR1_next = ins.d1;
    WB_DR2_next = ins.d2;
    WB_ADDRESS_next = ins.addr;
    dcache_ack = ack;
    @(negedge CLK);
    e_req    = m_v & m_i.st;
    e_stall  = e_req & ~ack;
    e_commit = m_v & (~m_i.st | ack);
    e_term   = e_commit & m_i.rep & ((m_i.c == 32'd0) | m_i.f[ZF]);
    e_wdata  = (m_i.size == 2'd3) ? m_i.m : {32'd0, m_i.a};
    if (chk_en) begin
      check_val("gpr1_we", 64'(gpr1_we), 64'(e_commit & m_i.g1));
      check_val("gpr2_we", 64'(gpr2_we), 64'(e_commit & m_i.g2));
      check_val("mm_we", 64'(mm_we), 64'(e_commit & m_i.mm));
      check_val("flags_we", 64'(flags_we), 64'(e_commit & m_i.lf));
      check_val("dcache_req", 64'(dcache_req), 64'(e_req));
      check_val("WB_stall", 64'(WB_stall), 64'(e_stall));
      check_val("terminate", 64'(wb_repne_terminate_all), 64'(e_term));
      check_val("saved_count", 64'(saved_count), 64'(m_saved));
      check_val("dcache_err", 64'(dcache_err), 64'(m_err));
      if (e_commit & m_i.g1) begin
        check_val("gpr1_dr", 64'(gpr1_dr), 64'(m_i.d1));
        check_val("gpr1_data", 64'(gpr1_data), 64'(m_i.a));
      end
      if (e_commit & m_i.g2) begin
        check_val("gpr2_dr", 64'(gpr2_dr), 64'(m_i.d2));
        check_val("gpr2_data", 64'(gpr2_data), 64'(m_i.b));
      end
      if (e_commit & m_i.mm) begin
        check_val("mm_dr", 64'(mm_dr), 64'(m_i.d1));
        check_val("mm_data", mm_data, m_i.m);
      end
      if (e_commit & m_i.lf) begin
        check_val("flags_data", 64'(flags_data), 64'(m_i.f));
      end
      if (e_req) begin
        check_val("dcache_addr", 64'(dcache_addr), 64'(m_i.addr));
        check_val("dcache_wdata", dcache_wdata, e_wdata);
        check_val("dcache_size", 64'(dcache_size), 64'(m_i.size));
      end
    end
    @(posedge CLK);
    if (clr) begin
      m_v = 1'b0;
      m_err = 1'b0;
      m_saved = 32'd0;
      m_waited = 0;
      chk_en = 1'b1;
    end else begin
      if (e_commit && m_i.rep) m_saved = m_i.c;
      // Error once a single store has gone unacknowledged for the request
      // cycle plus TO cycles of waiting.
      if (e_stall) begin
        m_waited++;
        if (m_waited == TO + 1) m_err = 1'b1;
      end else begin
        m_waited = 0;
      end
      if (ld) begin
        m_i = ins;
        m_v = ins.v;
      end else if (!e_stall) begin
        m_v = 1'b0;
      end
    end
    #1;
  endtask

  function automatic instr_t rand_instr();
    instr_t r;
    r.v    = ($urandom_range(0, 4) != 0);
    r.size = 2'($urandom_range(0, 3));
    r.g1   = 1'($urandom_range(0, 1));
    r.g2   = 1'($urandom_range(0, 1));
    r.mm   = 1'($urandom_range(0, 1));
    r.st   = ($urandom_range(0, 4) < 2);
    r.rep  = ($urandom_range(0, 2) == 0);
    r.lf   = 1'($urandom_range(0, 1));
    r.a    = $urandom;
    r.b    = $urandom;
    r.c    = $urandom_range(0, 3);
    r.f    = $urandom;
    r.f[ZF] = ($urandom_range(0, 3) == 0);
    r.m    = {$urandom, $urandom};
    r.d1   = 3'($urandom_range(0, 7));
    r.d2   = 3'($urandom_range(0, 7));
    r.addr = $urandom;
    return r;
  endfunction

  instr_t z;
  instr_t t;

  initial begin
    z = '0;
    // Reset, then idle cycle checks the reset state
    apply(1'b1, 1'b0, z, 1'b0);
    apply(1'b0, 1'b0, z, 1'b0);

    // Plain GPR1 write commits once
    t = z; t.v = 1'b1; t.g1 = 1'b1; t.d1 = 3'd3; t.a = 32'h12345678;
    apply(1'b0, 1'b1, t, 1'b0);
    apply(1'b0, 1'b0, z, 1'b0);
    apply(1'b0, 1'b0, z, 1'b0);

    // Store with GPR2 write, ack after 3 stall cycles
    t = z; t.v = 1'b1; t.st = 1'b1; t.g2 = 1'b1; t.d2 = 3'd5; t.b = 32'hCAFEF00D;
    t.a = 32'hDEADBEEF; t.addr = 32'h00001000; t.size = 2'd2;
    apply(1'b0, 1'b1, t, 1'b0);
    for (int i = 0; i < 3; i++) apply(1'b0, 1'b0, z, 1'b0);
    apply(1'b0, 1'b0, z, 1'b1);
    apply(1'b0, 1'b0, z, 1'b0);

    // 64-bit store acked in its first cycle
    t = z; t.v = 1'b1; t.st = 1'b1; t.size = 2'd3; t.m = 64'h0123456789ABCDEF;
    t.addr = 32'h00002000; t.lf = 1'b1; t.f = 32'h00000055;
    apply(1'b0, 1'b1, t, 1'b0);
    apply(1'b0, 1'b0, z, 1'b1);
    apply(1'b0, 1'b0, z, 1'b0);

    // REPNE countdown 2,1,0 with ZF clear, then ZF-terminated count 5
    t = z; t.v = 1'b1; t.rep = 1'b1; t.c = 32'd2;
    apply(1'b0, 1'b1, t, 1'b0);
    t.c = 32'd1;
    apply(1'b0, 1'b1, t, 1'b0);
    t.c = 32'd0;
    apply(1'b0, 1'b1, t, 1'b0);
    t.c = 32'd5; t.f = 32'h00000040;
    apply(1'b0, 1'b1, t, 1'b0);
    t = z; t.v = 1'b1; t.c = 32'd0;   // count zero without REPNE: no pulse
    apply(1'b0, 1'b1, t, 1'b0);
    apply(1'b0, 1'b0, z, 1'b0);

    // Ack withheld past the timeout, then a late ack; error stays set
    t = z; t.v = 1'b1; t.st = 1'b1; t.g1 = 1'b1; t.d1 = 3'd1; t.a = 32'h0000BEEF;
    t.addr = 32'h00003000;
    apply(1'b0, 1'b1, t, 1'b0);
    for (int i = 0; i < 7; i++) apply(1'b0, 1'b0, z, 1'b0);
    apply(1'b0, 1'b0, z, 1'b1);
    apply(1'b0, 1'b0, z, 1'b0);
    apply(1'b0, 1'b0, z, 1'b0);

    // REPNE commit (count 7), then a store reset in its second stall cycle
    t = z; t.v = 1'b1; t.rep = 1'b1; t.c = 32'd7;
    apply(1'b0, 1'b1, t, 1'b0);
    t = z; t.v = 1'b1; t.st = 1'b1; t.g1 = 1'b1; t.addr = 32'h00004000;
    apply(1'b0, 1'b1, t, 1'b0);
    apply(1'b0, 1'b0, z, 1'b0);
    apply(1'b1, 1'b0, z, 1'b0);
    apply(1'b0, 1'b0, z, 1'b0);
    apply(1'b0, 1'b0, z, 1'b0);

    // Random traffic; never loads while the model says execute is stalled
    for (int n = 0; n < 600; n++) begin
      logic r_clr, r_ack, r_ld;
      r_clr = ($urandom_range(0, 79) == 0);
      r_ack = (m_v & m_i.st) ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
      r_ld  = !exp_stall(r_ack) && ($urandom_range(0, 3) != 0);
      apply(r_clr, r_ld, rand_instr(), r_ack);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
